md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Runs MULT/MULTU/DIV/DIVU
//  with fixed multi-cycle latency into private HI/LO; serves MTHI/MTLO/MFHI/MFLO.
//  Drives busy, which the stall unit ANDs with the D-stage "is MD instruction" flag to freeze D.
// PARAMETERS
//  MULT_CYCLES  5   cycles from start to HI/LO commit for MULT/MULTU (>=1)
//  DIV_CYCLES   10  cycles from start to HI/LO commit for DIV/DIVU (>=1)
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  reset    in   1   synchronous, active-high; clears all state
//  start    in   1   one-cycle pulse: E-stage instr is MULT/MULTU/DIV/DIVU
//  md_op    in   3   operation select (package encoding), valid with start/we
//  we       in   1   E-stage instr is MTHI/MTLO (md_op picks target)
//  A        in   32  rs value (forwarded)
//  B        in   32  rt value (forwarded)
//  rd_sel   in   1   0 = LO, 1 = HI for MFLO/MFHI
//  busy     out  1   computation in flight, incl. the start cycle
//  HI       out  32  architectural HI register
//  LO       out  32  architectural LO register
//  md_out   out  32  rd_sel ? HI : LO (combinational, for MFHI/MFLO result)
// BEHAVIOUR
//  - Reset: cnt=0, HI=0, LO=0, pending result regs=0; busy=0 (start has no effect that cycle).
//  - State: cnt (4+ bits, sized for max parameter); idle when cnt==0.
//  - busy = start | (cnt != 0). Combinational from start so a D-stage MD instr stalls in the
//    same cycle the MD op enters E.
//  - Accept: start && cnt==0 && !reset -> compute into res_hi/res_lo at that edge;
//    cnt <= MULT_CYCLES or DIV_CYCLES. start while cnt!=0 ignored (stall unit prevents it).
//  - Count: cnt!=0 -> cnt <= cnt-1; on edge where cnt==1, HI<=res_hi, LO<=res_lo, cnt<=0.
//    busy falls the cycle after commit; latency start-edge to HI/LO visible = N cycles.
//  - MULT: signed 64-bit {HI,LO} = $signed(A)*$signed(B). MULTU: unsigned 64-bit product.
//  - DIV: LO = signed quotient (trunc toward zero), HI = signed remainder (sign of A).
//    DIVU: unsigned quot/rem. B==0: operation still takes DIV_CYCLES, HI/LO left unchanged.
//  - MTHI/MTLO: we && cnt==0 -> HI or LO <= A next edge. we while cnt!=0 ignored.
//    we and start same cycle: start wins, we ignored.
//  - MFHI/MFLO read HI/LO directly; committed values only, never res_hi/res_lo.
//  - Reset mid-operation: abandons op; cnt=0, HI=LO=0 next edge.
// STRUCTURE
//  - Shared package: md_op encoding (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3,
//    MD_MTHI=4, MD_MTLO=5), MULT_CYCLES/DIV_CYCLES defaults; E-stage decoder uses same package.
//  - Single module; no sub-module. Arithmetic via */ and % on 32-bit operands, signed casts
//    for MULT/DIV.
// TESTING
//  1 reset: assert reset 2 cycles -> busy=0, HI=LO=0, md_out=0.
//  2 MULT A=-3 B=7, start 1 cycle -> busy high start cycle + 5 more; HI=FFFFFFFF LO=FFFFFFEB
//    visible 5 cycles after start edge, busy low next cycle.
//  3 DIVU A=100 B=7 -> after 10 cycles LO=14 HI=2; DIV A=-7 B=2 -> LO=FFFFFFFD HI=FFFFFFFF.
//  4 MTHI A=12345678 while idle -> HI=12345678 next cycle; MTLO while busy -> LO unchanged.
//  5 DIV B=0 with HI=LO=5 -> busy for 10+1 cycles, HI=LO=5 after; second start during busy
//    ignored (commit matches first op only).
//  6 reset at cycle 3 of a MULT -> cnt=0, busy=0 next cycle, HI=LO=0, no later commit.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the E-stage decoder.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Counter width that holds the larger latency, never below 4 bits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit with private HI/LO; result is held pending until the
// latency counter expires, then committed.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam int unsigned CntW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic            res_ok_q, res_ok_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    md_op_e             op;

    // Divisor forced non-zero so B==0 never produces X; that result is discarded anyway.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        div_b  = (B == 32'd0) ? 32'd1 : B;
        quot_s = $signed(A) / $signed(div_b);
        rem_s  = $signed(A) % $signed(div_b);
        quot_u = A / div_b;
        rem_u  = A % div_b;
    end

    always_comb begin
        op       = md_op_e'(md_op);
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_ok_d = res_ok_q;
        if (cnt_q == '0) begin
            if (start) begin
                case (op)
                    MD_MULT: begin
                        {res_hi_d, res_lo_d} = prod_s;
                        res_ok_d = 1'b1;
                        cnt_d    = CntW'(MULT_CYCLES);
                    end
                    MD_MULTU: begin
                        {res_hi_d, res_lo_d} = prod_u;
                        res_ok_d = 1'b1;
                        cnt_d    = CntW'(MULT_CYCLES);
                    end
                    MD_DIV: begin
                        res_hi_d = rem_s;
                        res_lo_d = quot_s;
                        res_ok_d = (B != 32'd0);
                        cnt_d    = CntW'(DIV_CYCLES);
                    end
                    MD_DIVU: begin
                        res_hi_d = rem_u;
                        res_lo_d = quot_u;
                        res_ok_d = (B != 32'd0);
                        cnt_d    = CntW'(DIV_CYCLES);
                    end
                    default: ;
                endcase
            end else if (we) begin
                if (op == MD_MTHI) hi_d = A;
                else if (op == MD_MTLO) lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1) && res_ok_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_ok_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_ok_q <= res_ok_d;
        end
    end

    // Combinational from start so the D-stage stall asserts in the issue cycle.
    assign busy   = start | (cnt_q != '0);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign md_out = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic results, MTHI/MTLO and reset abort.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, we, rd_sel;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, md_out;

    int n_checks = 0;
    int n_pass   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .we     (we),
        .A      (A),
        .B      (B),
        .rd_sel (rd_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and return the number of cycles busy stayed high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        md_op = op; A = a; B = b; start = 1'b1;
        #1;
        n = 0;
        while (busy && n < 40) begin
            step();
            start = 1'b0;
            n++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; we = 1'b0; rd_sel = 1'b0;
        md_op = 3'd0; A = '0; B = '0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_mdout", md_out, 32'd0);
        reset = 1'b0;

        // MULT -3 * 7 with per-cycle latency checks
        md_op = MD_MULT; A = 32'hFFFF_FFFD; B = 32'd7; start = 1'b1;
        #1;
        check("mult_busy_start", {31'd0, busy}, 32'd1);
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("mult_busy_cnt", {31'd0, busy}, 32'd1);
            check("mult_hi_pending", HI, 32'd0);
            step();
        end
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFEB);
        check("mult_busy_done", {31'd0, busy}, 32'd0);
        rd_sel = 1'b1; #1;
        check("mult_mdout_hi", md_out, 32'hFFFF_FFFF);
        rd_sel = 1'b0; #1;
        check("mult_mdout_lo", md_out, 32'hFFFF_FFEB);

        run_op(MD_DIVU, 32'd100, 32'd7, n);
        check("divu_lat", n, 32'd11);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
        check("div_lat", n, 32'd11);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // MTHI while idle
        we = 1'b1; md_op = MD_MTHI; A = 32'h1234_5678;
        step();
        we = 1'b0;
        check("mthi", HI, 32'h1234_5678);

        // MTLO attempted while a MULTU is in flight
        md_op = MD_MULTU; A = 32'd2; B = 32'd3; start = 1'b1;
        step();
        start = 1'b0; we = 1'b1; md_op = MD_MTLO; A = 32'hDEAD_BEEF;
        step();
        we = 1'b0;
        check("mtlo_busy_ignored", LO, 32'hFFFF_FFFD);
        for (int i = 0; i < 4; i++) step();
        check("multu_lo", LO, 32'd6);
        check("multu_hi", HI, 32'd0);

        // start and we together: start wins
        we = 1'b1; md_op = MD_MULTU; A = 32'd4; B = 32'd5; start = 1'b1;
        step();
        we = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("start_wins_lo", LO, 32'd20);

        // Preload HI=LO=5, then divide by zero with a second start issued mid-op
        we = 1'b1; md_op = MD_MTHI; A = 32'd5; step();
        md_op = MD_MTLO; step();
        we = 1'b0;
        md_op = MD_DIV; A = 32'd9; B = 32'd0; start = 1'b1;
        step();
        md_op = MD_MULTU; A = 32'd3; B = 32'd3;
        step();
        start = 1'b0;
        n = 2;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("div0_lat", n, 32'd11);
        check("div0_hi", HI, 32'd5);
        check("div0_lo", LO, 32'd5);
        repeat (6) step();
        check("div0_no_late_commit", LO, 32'd5);

        // Reset in the middle of a MULT
        md_op = MD_MULT; A = 32'd4; B = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_hi", HI, 32'd0);
        check("rstmid_lo", LO, 32'd0);
        repeat (6) step();
        check("rstmid_no_commit", LO, 32'd0);
        check("rstmid_busy_late", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
